data_packet_checker: RTL
========================

Name: data_packet_checker

Overview:
- Avalon-ST sink that terminates the packet stream from the data packet generator and verifies it word by word.
- Checks the word sequence: a 16-bit dual counter in which each half advances by 2 per accepted beat. Also checks framing (sop/eop/empty) and packet byte length.
- Provides programmable ready back-pressure and an Avalon-MM register slave for control, counters and first-error capture.
- Sits at the receive end of the sim/loopback data path.

Parameters:
- CNT_W, 32: width of the packet and error counters.
- LEN_W, 16: width of the packet byte counter and the expected-length field.

Ports:
- csi_clock_clk  in  1  single clock.
- csi_clock_reset_n  in  1  asynchronous, active-low reset.
- avs_s0_write  in  1  register write strobe.
- avs_s0_read  in  1  register read strobe (no side effects).
- avs_s0_address  in  3  register select.
- avs_s0_byteenable  in  4  byte lanes for writes.
- avs_s0_writedata  in  32  write data.
- avs_s0_readdata  out  32  combinational read mux, zero latency.
- asi_snk0_valid  in  1  beat valid.
- asi_snk0_ready  out  1  sink ready.
- asi_snk0_data  in  32  beat data.
- asi_snk0_empty  in  2  empty bytes, qualified by eop only.
- asi_snk0_startofpacket  in  1  first beat of a packet.
- asi_snk0_endofpacket  in  1  last beat of a packet.
- asi_snk0_error  in  1  upstream error flag.

Behaviour:
- Accept = asi_snk0_valid & asi_snk0_ready.
- Reset (async, active-low): every register, counter and flag goes to 0, except ready_pattern = 0xFFFF. State = IDLE; asi_snk0_ready = 0.
- Register map (byte enables honoured on RW fields):
  - 0 CTRL: bit0 go RW; bit1 running RO; bit2 resync_en RW; bits[11:8] sticky flags W1C (data, framing, length, sink_error); bits[31:16] ready_pattern RW.
  - 1 LEN: [15:0] expected packet byte count; bit16 len_check_en.
  - 2 INIT: 32-bit seed. Any write also loads expected <= written value on the next clock.
  - 3 PKT_CNT: write-any clears.
  - 4 ERR_CNT: write-any clears; saturates at all-ones.
  - 5 LAST_LEN: RO, byte count of the last completed packet.
  - 6 FIRST_RX: RO, data of the first mismatching beat since the last clear.
  - 7 FIRST_EXP: RO, expected value at that mismatch.
  - Writing 3 or 4 re-arms first-error capture.
- Running: set the cycle after go = 1. Clears when go = 0 and state is IDLE/WAIT_SOP, or on an accepted eop while go = 0. A packet in flight is always completed.
- Ready back-pressure:
  - asi_snk0_ready = running & ready_pattern_rot[0]. This is registered-free: a combinational output of registered terms.
  - ready_pattern_rot rotates right by 1 every clock while running.
  - It reloads from ready_pattern on any write to CTRL.
  - A pattern value of 0 is treated as 0xFFFF.
- FSM:
  - IDLE -> WAIT_SOP when running.
  - WAIT_SOP -> IN_PKT on accepted sop & !eop.
  - WAIT_SOP -> WAIT_SOP on accepted sop & eop (single-beat packet, counted and completed).
  - IN_PKT -> WAIT_SOP on accepted eop.
  - WAIT_SOP -> IDLE when !running.
- Framing errors, each setting the framing flag with ERR_CNT += 1:
  - Accepted beat without sop in WAIT_SOP: beat dropped from length accounting; data still checked.
  - Accepted sop in IN_PKT: treated as the start of a new packet; the old packet is not counted.
- Data check on every accepted beat:
  - Mismatch if data != expected; sets the data flag and ERR_CNT += 1.
  - Next expected = {exp[31:16]+2, exp[15:0]+2}, each half wrapping mod 2^16.
  - If mismatch and resync_en: the next expected is computed from the received data instead.
- Length: pkt_bytes starts at 4 on sop and adds 4 per later beat; on eop it subtracts empty. Saturates at 0xFFFF.
  - On eop: LAST_LEN <= pkt_bytes and PKT_CNT += 1.
  - If len_check_en and pkt_bytes != LEN: length flag set and ERR_CNT += 1.
- Accepted beat with asi_snk0_error = 1: sink_error flag set and ERR_CNT += 1.
- Multiple errors on one beat: ERR_CNT increments by 1 only; all relevant flags are set.
- Simultaneous events:
  - PKT_CNT / ERR_CNT clear beats a same-cycle increment; the result is 0.
  - INIT load beats a same-cycle advance. That beat is compared against the old expected.
  - W1C of a flag loses to a same-cycle set.
- Counters wrap (PKT_CNT) or saturate (ERR_CNT) at 2^CNT_W-1.

Decomposition:
- Package data_packet_pkg holds:
  - the FSM state enum;
  - the register address constants;
  - the CTRL bit positions;
  - a function next_word(x) returning {x[31:16]+2, x[15:0]+2}. The generator's model in the bench reuses it.
- One natural sub-module: data_packet_ready_shaper (pattern rotate/reload, ready output).

Test Plan:
- INIT = 0x00010002, go = 1, pattern 0xFFFF; send 3-beat packet 0x00010002, 0x00030004, 0x00050006 with empty = 2 on eop -> PKT_CNT = 1, LAST_LEN = 10, ERR_CNT = 0, flags 0.
- Wrap: INIT = 0xFFFEFFFF; beats 0xFFFEFFFF then 0x00000001 -> no error; expected afterwards = 0x00020003.
- Corrupt beat 2 to 0xDEADBEEF with resync_en = 0 -> data flag set, ERR_CNT = 1, FIRST_RX = 0xDEADBEEF, FIRST_EXP = 0x00030004; beat 3 = 0x00050006 passes.
- LEN = 12 with len_check_en set, 3-beat packet with empty = 2 -> length flag set, ERR_CNT = 1. Write 0x400 to CTRL -> length flag cleared.
- Pattern 0x5555 -> ready toggles 1,0,1,0 from the first running cycle; a 4-beat packet completes in 8 cycles with zero errors.
- Clear go mid-packet -> running stays 1 until the accepted eop, then 0. Assert reset_n low mid-packet -> all counters 0, ready 0 immediately.

Source files
------------

// File: rtl/data_packet_pkg.sv
// data_packet_pkg
// Shared definitions for the data packet checker: FSM state encoding,
// register addresses, CTRL bit positions and the word-sequence helpers.
// The expected word sequence is a dual 16-bit counter where each half
// advances by 2 on every accepted beat, wrapping independently.
package data_packet_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_SOP = 2'd1,
        ST_IN_PKT   = 2'd2
    } state_e;

    localparam logic [2:0] ADDR_CTRL      = 3'd0;
    localparam logic [2:0] ADDR_LEN       = 3'd1;
    localparam logic [2:0] ADDR_INIT      = 3'd2;
    localparam logic [2:0] ADDR_PKT_CNT   = 3'd3;
    localparam logic [2:0] ADDR_ERR_CNT   = 3'd4;
    localparam logic [2:0] ADDR_LAST_LEN  = 3'd5;
    localparam logic [2:0] ADDR_FIRST_RX  = 3'd6;
    localparam logic [2:0] ADDR_FIRST_EXP = 3'd7;

    localparam int CTRL_GO_BIT      = 0;
    localparam int CTRL_RUNNING_BIT = 1;
    localparam int CTRL_RESYNC_BIT  = 2;
    localparam int CTRL_FLAG_LSB    = 8;
    localparam int CTRL_PATTERN_LSB = 16;
    localparam int LEN_EN_BIT       = 16;

    // Sticky flag positions inside the 4-bit flag field of CTRL
    localparam int FLAG_DATA    = 0;
    localparam int FLAG_FRAMING = 1;
    localparam int FLAG_LENGTH  = 2;
    localparam int FLAG_SINK    = 3;

    // Next word of the dual counter; each half wraps modulo 2^16
    function automatic logic [31:0] next_word(input logic [31:0] x);
        return {x[31:16] + 16'd2, x[15:0] + 16'd2};
    endfunction

    // Byte-lane merge of write data into an existing register image
    function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  be);
        logic [31:0] r;
        r = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = wdata[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/data_packet_checker_if.sv
// data_packet_checker_if
// Bundles the Avalon-MM register slave (avs_s0_*) and the Avalon-ST sink
// (asi_snk0_*) of the checker. The slave modport is the checker side,
// the master modport is the side that drives registers and stream beats.
interface data_packet_checker_if;

    logic        avs_s0_write;
    logic        avs_s0_read;
    logic [2:0]  avs_s0_address;
    logic [3:0]  avs_s0_byteenable;
    logic [31:0] avs_s0_writedata;
    logic [31:0] avs_s0_readdata;

    logic        asi_snk0_valid;
    logic        asi_snk0_ready;
    logic [31:0] asi_snk0_data;
    logic [1:0]  asi_snk0_empty;
    logic        asi_snk0_startofpacket;
    logic        asi_snk0_endofpacket;
    logic        asi_snk0_error;

    modport master (
        output avs_s0_write, avs_s0_read, avs_s0_address, avs_s0_byteenable, avs_s0_writedata,
        input  avs_s0_readdata,
        output asi_snk0_valid, asi_snk0_data, asi_snk0_empty,
        output asi_snk0_startofpacket, asi_snk0_endofpacket, asi_snk0_error,
        input  asi_snk0_ready
    );

    modport slave (
        input  avs_s0_write, avs_s0_read, avs_s0_address, avs_s0_byteenable, avs_s0_writedata,
        output avs_s0_readdata,
        input  asi_snk0_valid, asi_snk0_data, asi_snk0_empty,
        input  asi_snk0_startofpacket, asi_snk0_endofpacket, asi_snk0_error,
        output asi_snk0_ready
    );

endinterface

// File: rtl/data_packet_ready_shaper.sv
// data_packet_ready_shaper
// Generates sink ready from a 16-bit rotating back-pressure pattern.
// Ports:
//   clk_i      clock
//   rst_ni     asynchronous active-low reset
//   running_i  checker running; enables rotation and gates ready
//   reload_i   reload the rotator (any CTRL write)
//   pattern_i  pattern to load; zero means always ready
//   ready_o    combinational ready = running & rotator bit 0
module data_packet_ready_shaper (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        running_i,
    input  logic        reload_i,
    input  logic [15:0] pattern_i,
    output logic        ready_o
);

    logic [15:0] rot_q, rot_d;

    // Reload takes priority over rotation so a CTRL write always restarts
    // the pattern from bit 0; a zero pattern would stall forever, so it
    // is replaced by all-ones.
    always_comb begin
        rot_d = rot_q;
        if (reload_i) begin
            rot_d = (pattern_i == 16'h0000) ? 16'hFFFF : pattern_i;
        end else if (running_i) begin
            rot_d = {rot_q[0], rot_q[15:1]};
        end
    end

    // Rotator register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rot_q <= '0;
        else         rot_q <= rot_d;
    end

    assign ready_o = running_i & rot_q[0];

endmodule

// File: rtl/data_packet_checker.sv
// data_packet_checker
// Avalon-ST sink that verifies the dual-counter word sequence, packet
// framing and packet byte length, with an Avalon-MM register slave for
// control, counters and first-error capture.
// Ports:
//   csi_clock_clk      clock
//   csi_clock_reset_n  asynchronous active-low reset
//   bus                data_packet_checker_if.slave (avs_s0_* and asi_snk0_*)
module data_packet_checker
    import data_packet_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int LEN_W = 16
) (
    input  logic                 csi_clock_clk,
    input  logic                 csi_clock_reset_n,
    data_packet_checker_if.slave bus
);

    localparam logic [LEN_W:0] BEAT_BYTES = (LEN_W+1)'(4);

    state_e             state_q, state_d;
    logic               go_q, go_d, running_q, running_d, resync_en_q, resync_en_d;
    logic               len_check_en_q, len_check_en_d, first_valid_q, first_valid_d;
    logic [3:0]         flags_q, flags_d;
    logic [15:0]        ready_pattern_q, ready_pattern_d;
    logic [LEN_W-1:0]   len_q, len_d, pkt_bytes_q, pkt_bytes_d, last_len_q, last_len_d;
    logic [31:0]        init_q, init_d, expected_q, expected_d;
    logic [31:0]        first_rx_q, first_rx_d, first_exp_q, first_exp_d;
    logic [CNT_W-1:0]   pkt_cnt_q, pkt_cnt_d, err_cnt_q, err_cnt_d;

    logic               ready, accept, in_pkt, sop, eop;
    logic               data_err, frame_err, sink_err, len_err, any_err, counted, complete;
    logic               wr_ctrl, wr_len, wr_init, wr_pkt, wr_err;
    logic [31:0]        ctrl_rd, len_rd, ctrl_wr, len_wr;
    logic [3:0]         w1c;
    logic [LEN_W:0]     bytes_sum;
    logic [LEN_W-1:0]   beat_bytes, final_bytes;

    assign sop      = bus.asi_snk0_startofpacket;
    assign eop      = bus.asi_snk0_endofpacket;
    assign wr_ctrl  = bus.avs_s0_write && (bus.avs_s0_address == ADDR_CTRL);
    assign wr_len   = bus.avs_s0_write && (bus.avs_s0_address == ADDR_LEN);
    assign wr_init  = bus.avs_s0_write && (bus.avs_s0_address == ADDR_INIT);
    assign wr_pkt   = bus.avs_s0_write && (bus.avs_s0_address == ADDR_PKT_CNT);
    assign wr_err   = bus.avs_s0_write && (bus.avs_s0_address == ADDR_ERR_CNT);
    assign ctrl_wr  = be_merge(ctrl_rd, bus.avs_s0_writedata, bus.avs_s0_byteenable);
    assign len_wr   = be_merge(len_rd, bus.avs_s0_writedata, bus.avs_s0_byteenable);
    assign w1c      = bus.avs_s0_writedata[CTRL_FLAG_LSB +: 4] & {4{bus.avs_s0_byteenable[1]}};

    // Beat classification. A beat belongs to a packet when it opens one
    // (sop) or arrives inside one; stray beats outside a packet are still
    // data-checked but never enter the length accounting.
    assign accept      = bus.asi_snk0_valid & ready;
    assign in_pkt      = (state_q == ST_IN_PKT);
    assign data_err    = accept & (bus.asi_snk0_data != expected_q);
    assign frame_err   = accept & (in_pkt ? sop : ~sop);
    assign sink_err    = accept & bus.asi_snk0_error;
    assign counted     = accept & (sop | in_pkt);
    assign complete    = counted & eop;
    assign bytes_sum   = {1'b0, pkt_bytes_q} + BEAT_BYTES;
    assign beat_bytes  = sop ? BEAT_BYTES[LEN_W-1:0]
                             : (bytes_sum[LEN_W] ? '1 : bytes_sum[LEN_W-1:0]);
    assign final_bytes = beat_bytes - LEN_W'(bus.asi_snk0_empty);
    assign len_err     = complete & len_check_en_q & (final_bytes != len_q);
    assign any_err     = data_err | frame_err | sink_err | len_err;

    // Register images used both for readback and as the base for
    // byte-enable merging on writes.
    always_comb begin
        ctrl_rd = '0;
        ctrl_rd[CTRL_GO_BIT]               = go_q;
        ctrl_rd[CTRL_RUNNING_BIT]          = running_q;
        ctrl_rd[CTRL_RESYNC_BIT]           = resync_en_q;
        ctrl_rd[CTRL_FLAG_LSB +: 4]        = flags_q;
        ctrl_rd[CTRL_PATTERN_LSB +: 16]    = ready_pattern_q;
        len_rd = '0;
        len_rd[LEN_W-1:0]                  = len_q;
        len_rd[LEN_EN_BIT]                 = len_check_en_q;
    end

    // Zero-latency read mux; reads never change state.
    always_comb begin
        bus.avs_s0_readdata = '0;
        case (bus.avs_s0_address)
            ADDR_CTRL:      bus.avs_s0_readdata = ctrl_rd;
            ADDR_LEN:       bus.avs_s0_readdata = len_rd;
            ADDR_INIT:      bus.avs_s0_readdata = init_q;
            ADDR_PKT_CNT:   bus.avs_s0_readdata = 32'(pkt_cnt_q);
            ADDR_ERR_CNT:   bus.avs_s0_readdata = 32'(err_cnt_q);
            ADDR_LAST_LEN:  bus.avs_s0_readdata = 32'(last_len_q);
            ADDR_FIRST_RX:  bus.avs_s0_readdata = first_rx_q;
            ADDR_FIRST_EXP: bus.avs_s0_readdata = first_exp_q;
            default:        bus.avs_s0_readdata = '0;
        endcase
    end

    // Next-state logic for the FSM and every register. Ordering inside
    // each field encodes the same-cycle priorities: counter clears beat
    // increments, an INIT write beats the sequence advance, and a flag
    // set beats its W1C clear.
    always_comb begin
        go_d            = go_q;
        resync_en_d     = resync_en_q;
        ready_pattern_d = ready_pattern_q;
        flags_d         = flags_q;
        len_d           = len_q;
        len_check_en_d  = len_check_en_q;
        init_d          = init_q;
        expected_d      = expected_q;
        pkt_cnt_d       = pkt_cnt_q;
        err_cnt_d       = err_cnt_q;
        pkt_bytes_d     = pkt_bytes_q;
        last_len_d      = last_len_q;
        first_valid_d   = first_valid_q;
        first_rx_d      = first_rx_q;
        first_exp_d     = first_exp_q;
        state_d         = state_q;

        if (wr_ctrl) begin
            go_d            = ctrl_wr[CTRL_GO_BIT];
            resync_en_d     = ctrl_wr[CTRL_RESYNC_BIT];
            ready_pattern_d = ctrl_wr[CTRL_PATTERN_LSB +: 16];
            flags_d         = flags_q & ~w1c;
        end
        flags_d[FLAG_DATA]    = flags_d[FLAG_DATA]    | data_err;
        flags_d[FLAG_FRAMING] = flags_d[FLAG_FRAMING] | frame_err;
        flags_d[FLAG_LENGTH]  = flags_d[FLAG_LENGTH]  | len_err;
        flags_d[FLAG_SINK]    = flags_d[FLAG_SINK]    | sink_err;

        if (wr_len) begin
            len_d          = len_wr[LEN_W-1:0];
            len_check_en_d = len_wr[LEN_EN_BIT];
        end

        if (wr_init) begin
            init_d     = be_merge(init_q, bus.avs_s0_writedata, bus.avs_s0_byteenable);
            expected_d = init_d;
        end else if (accept) begin
            expected_d = next_word((data_err && resync_en_q) ? bus.asi_snk0_data : expected_q);
        end

        if (wr_pkt)        pkt_cnt_d = '0;
        else if (complete) pkt_cnt_d = pkt_cnt_q + CNT_W'(1);

        if (wr_err)                              err_cnt_d = '0;
        else if (any_err && (err_cnt_q != '1))   err_cnt_d = err_cnt_q + CNT_W'(1);

        if (counted)  pkt_bytes_d = beat_bytes;
        if (complete) last_len_d  = final_bytes;

        if (wr_pkt || wr_err) begin
            first_valid_d = 1'b0;
        end else if (data_err && !first_valid_q) begin
            first_valid_d = 1'b1;
            first_rx_d    = bus.asi_snk0_data;
            first_exp_d   = expected_q;
        end

        case (state_q)
            ST_IDLE, ST_WAIT_SOP: begin
                if (accept && sop && !eop)                   state_d = ST_IN_PKT;
                else if (state_q == ST_IDLE && running_q)    state_d = ST_WAIT_SOP;
                else if (state_q == ST_WAIT_SOP && !running_q) state_d = ST_IDLE;
            end
            ST_IN_PKT: if (accept && eop) state_d = ST_WAIT_SOP;
            default:   state_d = ST_IDLE;
        endcase

        // Running holds while a packet is still open so it always completes.
        running_d = go_q | (running_q & (state_d == ST_IN_PKT));
    end

    // State register; everything clears except the ready pattern.
    always_ff @(posedge csi_clock_clk or negedge csi_clock_reset_n) begin
        if (!csi_clock_reset_n) begin
            state_q         <= ST_IDLE;
            go_q            <= 1'b0;
            running_q       <= 1'b0;
            resync_en_q     <= 1'b0;
            ready_pattern_q <= 16'hFFFF;
            flags_q         <= '0;
            len_q           <= '0;
            len_check_en_q  <= 1'b0;
            init_q          <= '0;
            expected_q      <= '0;
            pkt_cnt_q       <= '0;
            err_cnt_q       <= '0;
            pkt_bytes_q     <= '0;
            last_len_q      <= '0;
            first_valid_q   <= 1'b0;
            first_rx_q      <= '0;
            first_exp_q     <= '0;
        end else begin
            state_q         <= state_d;
            go_q            <= go_d;
            running_q       <= running_d;
            resync_en_q     <= resync_en_d;
            ready_pattern_q <= ready_pattern_d;
            flags_q         <= flags_d;
            len_q           <= len_d;
            len_check_en_q  <= len_check_en_d;
            init_q          <= init_d;
            expected_q      <= expected_d;
            pkt_cnt_q       <= pkt_cnt_d;
            err_cnt_q       <= err_cnt_d;
            pkt_bytes_q     <= pkt_bytes_d;
            last_len_q      <= last_len_d;
            first_valid_q   <= first_valid_d;
            first_rx_q      <= first_rx_d;
            first_exp_q     <= first_exp_d;
        end
    end

    data_packet_ready_shaper u_ready_shaper (
        .clk_i     (csi_clock_clk),
        .rst_ni    (csi_clock_reset_n),
        .running_i (running_q),
        .reload_i  (wr_ctrl),
        .pattern_i (ready_pattern_d),
        .ready_o   (ready)
    );

    assign bus.asi_snk0_ready = ready;

endmodule
